// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction memory, aligns pc/instr for decode.
// Latency: one cycle from read_address to the if_* output; one bubble after a redirect.
// Backpressure: stall freezes the PC and parks the displayed instruction in a one-entry hold register.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   stall                             decode cannot take the current if_* output
//   redirect_valid, redirect_target   load a new byte-address PC (taken branch/jump)
//   read_address                      word index to instruction memory, {2'b00, pc[31:2]}
//   instruction_in                    memory data for the previous cycle's read_address
//   if_valid, if_pc, if_pc_plus4, if_instr   fetched instruction towards decode
//   fetch_fault                       sticky: an illegal PC was reached, fetch halted until reset
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] read_address,
  input  logic [31:0] instruction_in,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        fetch_fault
);

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        fault;
  logic        pc_legal;
  logic        capture;
  logic [31:0] sel_pc;

  // Word aligned and inside the memory; anything else halts fetch.
  assign pc_legal = (pc[1:0] == 2'b00) && (pc[31:2] < WORD_LIMIT);

  assign read_address = {2'b00, pc[31:2]};

  // instruction_in only matches req_pc on the first stalled cycle (the memory
  // re-reads pc afterwards), so the hold register must grab it right then.
  assign capture = stall && !hold_valid && req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= 32'h0;
      hold_valid <= 1'b0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      fault      <= 1'b0;
    end else if (fault || !pc_legal) begin
      // Halted: nothing new is issued and redirects are ignored, but an
      // instruction already on display still obeys stall/release.
      fault     <= 1'b1;
      req_valid <= 1'b0;
      if (capture) begin
        hold_valid <= 1'b1;
        hold_pc    <= req_pc;
        hold_instr <= instruction_in;
      end else if (!stall) begin
        hold_valid <= 1'b0;
      end
    end else if (redirect_valid) begin
      // Wins over stall; the in-flight and held instructions are wrong-path.
      pc         <= redirect_target;
      req_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      if (capture) begin
        hold_valid <= 1'b1;
        hold_pc    <= req_pc;
        hold_instr <= instruction_in;
      end
    end else begin
      // Normal advance; also consumes a held entry on stall release. pc is
      // still held_pc + 4 here, so nothing is skipped or repeated.
      hold_valid <= 1'b0;
      pc         <= pc + 32'd4;
      req_valid  <= 1'b1;
      req_pc     <= pc;
    end
  end

  always_comb begin
    if_valid = 1'b0;
    sel_pc   = req_pc;
    if_instr = 32'h0;
    if (hold_valid) begin
      if_valid = 1'b1;
      sel_pc   = hold_pc;
      if_instr = hold_instr;
    end else if (req_valid) begin
      if_valid = 1'b1;
      if_instr = instruction_in;
    end
  end

  assign if_pc       = sel_pc;
  assign if_pc_plus4 = sel_pc + 32'd4;
  assign fetch_fault = fault;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end that owns the program counter and drives `read_address` into the synchronous instruction memory. The memory returns data one cycle after the address. This block tracks that in-flight request so that PC, PC+4 and instruction reach the decode stage aligned, with a valid flag. It also handles downstream stalls, control-flow redirects (branch/jump) and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_WORDS, 32, number of 32-bit words in instruction memory; word indices >= this are out of range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  decode cannot accept the current `if_*` output this cycle.
- redirect_valid  in  1  load a new PC this cycle (taken branch/jump).
- redirect_target  in  32  byte-address target for the redirect.
- read_address  out  32  word index to instruction memory, equal to {2'b00, pc[31:2]}; combinational from the PC register.
- instruction_in  in  32  memory output; holds memory[read_address of the previous cycle].
- if_valid  out  1  `if_pc`, `if_pc_plus4` and `if_instr` form a valid fetched instruction.
- if_pc  out  32  byte address of `if_instr`.
- if_pc_plus4  out  32  `if_pc` + 4, modulo 2^32.
- if_instr  out  32  fetched instruction.
- fetch_fault  out  1  sticky fault flag; fetch halted.

Behaviour:
- State:
  - pc (32).
  - req_valid, req_pc: the request issued last cycle, aligned with `instruction_in`.
  - hold_valid, hold_pc, hold_instr: the output captured during a stall.
  - fault.
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; req_valid, hold_valid, fault <= 0; req_pc, hold_pc, hold_instr <= 0.
  - Outputs during and right after reset: if_valid=0, if_pc=0, if_pc_plus4=4, if_instr=0, fetch_fault=0.
  - Reset has priority over every other input, including mid-stall, mid-redirect and when fault is set.
- Issue rule: `pc` is a legal issue iff pc[1:0]==0 and pc[31:2] < IMEM_WORDS.
- Output mux:
  - If hold_valid: output hold_pc / hold_instr, if_valid=1.
  - Otherwise: output req_pc / instruction_in, if_valid=req_valid.
  - `if_pc_plus4` is always the selected pc + 4.
- Normal advance (no stall, no redirect, no fault, legal pc): pc <= pc+4; req_valid <= 1; req_pc <= pc.
- Throughput: one instruction per cycle; first valid output one cycle after rst deasserts (if_pc=RESET_PC).
- Stall (stall=1, no redirect):
  - pc, req_valid and req_pc hold. The memory keeps re-reading pc, which is harmless.
  - If !hold_valid && req_valid: capture hold_pc <= req_pc, hold_instr <= instruction_in, hold_valid <= 1.
  - The displayed output stays constant for the whole stall.
- Stall release (stall=0 with hold_valid=1): the held entry is consumed that cycle; hold_valid <= 0; pc advances normally.
  - The next cycle shows the instruction at the held pc + 4. No instruction is lost or duplicated.
- Redirect (redirect_valid=1):
  - Overrides stall. pc <= redirect_target; req_valid <= 0; hold_valid <= 0.
  - Cycle t+1: if_valid=0 (one bubble).
  - Cycle t+2: if_valid=1, if_pc=redirect_target, provided the target is legal and stall=0 at t+1.
- Fault (fault=0 and pc is not a legal issue, evaluated every non-reset cycle):
  - fault <= 1; req_valid <= 0; pc frozen.
  - A pending hold entry may still drain through the stall/release rules; no new instructions are issued.
  - While fault=1: redirect is ignored, if_valid=0 once hold drains, fetch_fault=1 until reset.
- Simultaneous redirect and stall: redirect wins and the held entry is discarded.
- Simultaneous redirect to an illegal target: accepted into pc; the fault fires the following cycle.
- Wrap: pc+4 wraps modulo 2^32 but is caught by the range check first.

Test Plan:
- Reset release, RESET_PC=0, memory words 0..3 = A,B,C,D → cycles 1..4 show if_valid=1 with (pc,instr) = (0,A),(4,B),(8,C),(12,D); read_address = 0,1,2,3…
- stall=1 for 3 cycles while showing (8,C) → if_pc=8, if_instr=C held all 3 cycles; after release the next is (12,D) with no duplicate or skip.
- redirect_valid=1, target=0x20, while showing (4,B) → next cycle if_valid=0; following cycle (0x20, mem[8]), if_pc_plus4=0x24.
- redirect_valid=1 and stall=1 in the same cycle while hold_valid=1 → hold discarded; bubble, then (target, mem[target>>2]).
- Sequential run to pc=0x80 with IMEM_WORDS=32 → last valid is (0x7C, mem[31]); fetch_fault=1 the next cycle and stays set; a later redirect to 0 is ignored. Separately, redirect target 0x6 → fault.
- rst=1 asserted mid-stream and during fault → outputs return to reset values next cycle; fetch restarts at RESET_PC with if_valid=1 one cycle after rst drops.
